// File: rtl/rt_pkg.sv
// Shared encodings for the register-transfer datapath core: command opcodes,
// ALU function codes and the micro-sequencer state type.
package rt_pkg;

   localparam logic [1:0] OP_MOVE = 2'b00;
   localparam logic [1:0] OP_ALU  = 2'b01;
   localparam logic [1:0] OP_MUL  = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;

   localparam logic [3:0] FN_ADD  = 4'd0;
   localparam logic [3:0] FN_SUB  = 4'd1;
   localparam logic [3:0] FN_AND  = 4'd2;
   localparam logic [3:0] FN_OR   = 4'd3;
   localparam logic [3:0] FN_SHR  = 4'd4;
   localparam logic [3:0] FN_SHRA = 4'd5;
   localparam logic [3:0] FN_SHL  = 4'd6;
   localparam logic [3:0] FN_ROR  = 4'd7;
   localparam logic [3:0] FN_ROL  = 4'd8;
   localparam logic [3:0] FN_NEG  = 4'd9;
   localparam logic [3:0] FN_NOT  = 4'd10;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD_Y = 2'd1,
      S_EXEC   = 2'd2,
      S_WRITE  = 2'd3
   } state_e;

endpackage

// File: rtl/rt_cmd_if.sv
// Command handshake bundle between a controller and the datapath core;
// done rides along so the controller sees completion on the same bundle.
interface rt_cmd_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 4
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [3:0]        cmd_alu;
   logic [REG_AW-1:0] cmd_ra;
   logic [REG_AW-1:0] cmd_rb;
   logic [REG_AW-1:0] cmd_rc;
   logic              cmd_use_imm;
   logic [DATA_W-1:0] cmd_imm;
   logic              done;

   modport master (
      output cmd_valid, cmd_op, cmd_alu, cmd_ra, cmd_rb, cmd_rc, cmd_use_imm, cmd_imm,
      input  cmd_ready, done
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_alu, cmd_ra, cmd_rb, cmd_rc, cmd_use_imm, cmd_imm,
      output cmd_ready, done
   );
endinterface

// File: rtl/rt_alu.sv
// Purely combinational ALU; the result is double width so the signed
// multiply fits, and every non-multiply function leaves the upper half zero.
module rt_alu
   import rt_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]   a,
   input  logic [DATA_W-1:0]   b,
   input  logic [3:0]          fn,
   input  logic                mul,
   output logic [2*DATA_W-1:0] z
);

   localparam int SH_W = $clog2(DATA_W);

   logic [SH_W-1:0]            sh;
   logic [2*DATA_W-1:0]        dbl;
   logic [2*DATA_W-1:0]        ror_v;
   logic [2*DATA_W-1:0]        rol_v;
   logic signed [2*DATA_W-1:0] prod;

   assign sh = b[SH_W-1:0];

   // Rotates shift a doubled copy of A so the wrapped bits fall out naturally.
   always_comb begin
      dbl   = {a, a};
      ror_v = dbl >> sh;
      rol_v = dbl << sh;
      prod  = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
      z     = '0;
      if (mul) begin
         z = prod;
      end else begin
         case (fn)
            FN_ADD:  z[DATA_W-1:0] = a + b;
            FN_SUB:  z[DATA_W-1:0] = a - b;
            FN_AND:  z[DATA_W-1:0] = a & b;
            FN_OR:   z[DATA_W-1:0] = a | b;
            FN_SHR:  z[DATA_W-1:0] = a >> sh;
            FN_SHRA: z[DATA_W-1:0] = $signed(a) >>> sh;
            FN_SHL:  z[DATA_W-1:0] = a << sh;
            FN_ROR:  z[DATA_W-1:0] = ror_v[DATA_W-1:0];
            FN_ROL:  z[DATA_W-1:0] = rol_v[2*DATA_W-1:DATA_W];
            FN_NEG:  z[DATA_W-1:0] = -b;
            FN_NOT:  z[DATA_W-1:0] = ~b;
            default: z = '0;
         endcase
      end
   end

endmodule

// File: rtl/rt_datapath_core.sv
// Register-transfer datapath core: register file, Y/Z/HI/LO and a four-state
// micro-sequencer that runs one MOVE, ALU or MUL transfer per accepted command.
module rt_datapath_core
   import rt_pkg::*;
#(
   parameter  int DATA_W   = 32,
   parameter  int NUM_REGS = 16,
   parameter  int R0_ZERO  = 1,
   localparam int REG_AW   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              clr,
   rt_cmd_if.slave           cmd,
   output logic              flag_z,
   output logic              flag_n,
   output logic [DATA_W-1:0] hi_out,
   output logic [DATA_W-1:0] lo_out,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   state_e              state_q, state_d;
   logic [1:0]          op_q, op_d;
   logic [3:0]          alu_q, alu_d;
   logic [REG_AW-1:0]   ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
   logic                use_imm_q, use_imm_d;
   logic [DATA_W-1:0]   imm_q, imm_d;
   logic [DATA_W-1:0]   y_q, y_d;
   logic [2*DATA_W-1:0] z_q, z_d;
   logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic                flag_z_q, flag_z_d, flag_n_q, flag_n_d;
   logic                done_q, done_d;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic [DATA_W-1:0]   regs_rd [NUM_REGS];
   logic [DATA_W-1:0]   alu_b;
   logic [DATA_W-1:0]   wr_val;
   logic [2*DATA_W-1:0] alu_z;

   // Every read path sees R0 as zero when the hard-zero option is on.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_rd[i] = ((R0_ZERO != 0) && (i == 0)) ? '0 : regs_q[i];
      end
   end

   assign alu_b = use_imm_q ? imm_q : regs_rd[rc_q];

   rt_alu #(.DATA_W(DATA_W)) u_alu (
      .a   (y_q),
      .b   (alu_b),
      .fn  (alu_q),
      .mul (op_q == OP_MUL),
      .z   (alu_z)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      alu_d     = alu_q;
      ra_d      = ra_q;
      rb_d      = rb_q;
      rc_d      = rc_q;
      use_imm_d = use_imm_q;
      imm_d     = imm_q;
      y_d       = y_q;
      z_d       = z_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      flag_z_d  = flag_z_q;
      flag_n_d  = flag_n_q;
      done_d    = 1'b0;
      regs_d    = regs_q;
      wr_val    = '0;
      case (state_q)
         S_IDLE: begin
            if (cmd.cmd_valid) begin
               op_d      = cmd.cmd_op;
               alu_d     = cmd.cmd_alu;
               ra_d      = cmd.cmd_ra;
               rb_d      = cmd.cmd_rb;
               rc_d      = cmd.cmd_rc;
               use_imm_d = cmd.cmd_use_imm;
               imm_d     = cmd.cmd_imm;
               case (cmd.cmd_op)
                  OP_MOVE:        state_d = S_WRITE;
                  OP_ALU, OP_MUL: state_d = S_LOAD_Y;
                  default:        done_d  = 1'b1;
               endcase
            end
         end
         S_LOAD_Y: begin
            y_d     = regs_rd[rb_q];
            state_d = S_EXEC;
         end
         S_EXEC: begin
            z_d     = alu_z;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            // MUL flags look at the whole product, not just the LO half.
            if (op_q == OP_MUL) begin
               hi_d     = z_q[2*DATA_W-1:DATA_W];
               lo_d     = z_q[DATA_W-1:0];
               flag_z_d = (z_q == '0);
               flag_n_d = z_q[2*DATA_W-1];
            end else begin
               wr_val   = (op_q == OP_MOVE) ? regs_rd[rb_q] : z_q[DATA_W-1:0];
               flag_z_d = (wr_val == '0);
               flag_n_d = wr_val[DATA_W-1];
               if (!((R0_ZERO != 0) && (ra_q == '0))) begin
                  regs_d[ra_q] = wr_val;
               end
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         alu_q     <= '0;
         ra_q      <= '0;
         rb_q      <= '0;
         rc_q      <= '0;
         use_imm_q <= 1'b0;
         imm_q     <= '0;
         y_q       <= '0;
         z_q       <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         flag_z_q  <= 1'b0;
         flag_n_q  <= 1'b0;
         done_q    <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         alu_q     <= alu_d;
         ra_q      <= ra_d;
         rb_q      <= rb_d;
         rc_q      <= rc_d;
         use_imm_q <= use_imm_d;
         imm_q     <= imm_d;
         y_q       <= y_d;
         z_q       <= z_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         flag_z_q  <= flag_z_d;
         flag_n_q  <= flag_n_d;
         done_q    <= done_d;
         regs_q    <= regs_d;
      end
   end

   assign cmd.cmd_ready = (state_q == S_IDLE);
   assign cmd.done      = done_q;
   assign flag_z        = flag_z_q;
   assign flag_n        = flag_n_q;
   assign hi_out        = hi_q;
   assign lo_out        = lo_q;
   assign dbg_data      = regs_rd[dbg_addr];

endmodule

// File: tb/tb_rt_datapath_core.sv
// Directed bench for rt_datapath_core: a 32-bit/16-register instance and an
// 8-bit/4-register instance, each driven through its own command interface.
module tb_rt_datapath_core;
   import rt_pkg::*;

   logic clk = 1'b0;
   logic clr;
   logic clr8;

   always #5 clk = ~clk;

   rt_cmd_if #(.DATA_W(32), .REG_AW(4)) bus32 ();
   rt_cmd_if #(.DATA_W(8),  .REG_AW(2)) bus8 ();

   logic        fz32, fn32, fz8, fn8;
   logic [31:0] hi32, lo32, dbg32;
   logic [7:0]  hi8, lo8, dbg8;
   logic [3:0]  dbga32;
   logic [1:0]  dbga8;

   int errors = 0;
   int checks = 0;

   rt_datapath_core #(.DATA_W(32), .NUM_REGS(16), .R0_ZERO(1)) dut32 (
      .clk      (clk),
      .clr      (clr),
      .cmd      (bus32.slave),
      .flag_z   (fz32),
      .flag_n   (fn32),
      .hi_out   (hi32),
      .lo_out   (lo32),
      .dbg_addr (dbga32),
      .dbg_data (dbg32)
   );

   rt_datapath_core #(.DATA_W(8), .NUM_REGS(4), .R0_ZERO(1)) dut8 (
      .clk      (clk),
      .clr      (clr8),
      .cmd      (bus8.slave),
      .flag_z   (fz8),
      .flag_n   (fn8),
      .hi_out   (hi8),
      .lo_out   (lo8),
      .dbg_addr (dbga8),
      .dbg_data (dbg8)
   );

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic curReady(input bit sel8);
      return sel8 ? bus8.cmd_ready : bus32.cmd_ready;
   endfunction

   function automatic logic curDone(input bit sel8);
      return sel8 ? bus8.done : bus32.done;
   endfunction

   task automatic setCmd(input bit sel8, input logic [1:0] op, input logic [3:0] fn,
                         input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc,
                         input logic use_imm, input logic [31:0] imm);
      if (sel8) begin
         bus8.cmd_op      = op;
         bus8.cmd_alu     = fn;
         bus8.cmd_ra      = ra[1:0];
         bus8.cmd_rb      = rb[1:0];
         bus8.cmd_rc      = rc[1:0];
         bus8.cmd_use_imm = use_imm;
         bus8.cmd_imm     = imm[7:0];
         bus8.cmd_valid   = 1'b1;
      end else begin
         bus32.cmd_op      = op;
         bus32.cmd_alu     = fn;
         bus32.cmd_ra      = ra;
         bus32.cmd_rb      = rb;
         bus32.cmd_rc      = rc;
         bus32.cmd_use_imm = use_imm;
         bus32.cmd_imm     = imm;
         bus32.cmd_valid   = 1'b1;
      end
   endtask

   // Issues one command and returns the cycle index (accept cycle = 1) of done.
   task automatic applyStimulus(input bit sel8, input logic [1:0] op, input logic [3:0] fn,
                                input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc,
                                input logic use_imm, input logic [31:0] imm, output int lat);
      int guard;
      @(negedge clk);
      setCmd(sel8, op, fn, ra, rb, rc, use_imm, imm);
      guard = 0;
      while (!curReady(sel8) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      #1;
      bus8.cmd_valid  = 1'b0;
      bus32.cmd_valid = 1'b0;
      lat = 1;
      while (!curDone(sel8) && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (lat >= 50) checkOutput("done_timeout", 64'd0, 64'd1);
   endtask

   task automatic readReg(input bit sel8, input logic [3:0] addr, output logic [31:0] val);
      if (sel8) dbga8 = addr[1:0];
      else      dbga32 = addr;
      #1;
      val = sel8 ? {24'h0, dbg8} : dbg32;
   endtask

   // Starts an ADD, pulls reset while it sits in EXEC, and confirms nothing lands.
   task automatic resetDuringExec(input bit sel8, input logic [3:0] ra, input logic [31:0] imm);
      int dones;
      logic [31:0] v;
      @(negedge clk);
      setCmd(sel8, OP_ALU, FN_ADD, ra, 4'd0, 4'd0, 1'b1, imm);
      @(posedge clk);
      #1;
      bus8.cmd_valid  = 1'b0;
      bus32.cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rstx_busy_in_exec", curReady(sel8), 1'b0);
      @(negedge clk);
      if (sel8) clr8 = 1'b0;
      else      clr  = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rstx_ready_after", curReady(sel8), 1'b1);
      checkOutput("rstx_done_after", curDone(sel8), 1'b0);
      @(negedge clk);
      clr  = 1'b1;
      clr8 = 1'b1;
      dones = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (curDone(sel8)) dones++;
      end
      checkOutput("rstx_no_done", dones, 0);
      readReg(sel8, ra, v);
      checkOutput("rstx_dest_zero", v, 32'h0);
      checkOutput("rstx_flags", sel8 ? {fz8, fn8} : {fz32, fn32}, 2'b00);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          lat;
      int          accepts;
      int          cyc1;
      logic [31:0] v;

      clr    = 1'b0;
      clr8   = 1'b0;
      dbga32 = '0;
      dbga8  = '0;
      setCmd(1'b0, OP_MOVE, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 32'd0);
      setCmd(1'b1, OP_MOVE, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 32'd0);
      bus32.cmd_valid = 1'b0;
      bus8.cmd_valid  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      clr  = 1'b1;
      clr8 = 1'b1;

      checkOutput("rst_ready", bus32.cmd_ready, 1'b1);
      checkOutput("rst_done", bus32.done, 1'b0);
      checkOutput("rst_flags", {fz32, fn32}, 2'b00);
      checkOutput("rst_hilo", {hi32, lo32}, 64'h0);

      // MOVE R5 <- R0 with hard-zero R0
      applyStimulus(1'b0, OP_MOVE, 4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 32'd0, lat);
      checkOutput("move_latency", lat, 2);
      readReg(1'b0, 4'd5, v);
      checkOutput("move_r5", v, 32'h0);
      checkOutput("move_flag_z", fz32, 1'b1);

      applyStimulus(1'b0, OP_ALU, FN_ADD, 4'd5, 4'd0, 4'd0, 1'b1, 32'h55, lat);
      readReg(1'b0, 4'd5, v);
      checkOutput("load_r5", v, 32'h55);
      applyStimulus(1'b0, OP_MOVE, 4'd0, 4'd0, 4'd5, 4'd0, 1'b0, 32'd0, lat);
      readReg(1'b0, 4'd0, v);
      checkOutput("r0_write_dropped", v, 32'h0);
      checkOutput("r0_write_flag_z", fz32, 1'b0);

      applyStimulus(1'b0, OP_ALU, FN_ADD, 4'd2, 4'd0, 4'd0, 1'b1, 32'h7, lat);
      applyStimulus(1'b0, OP_ALU, FN_ADD, 4'd3, 4'd0, 4'd0, 1'b1, 32'hFFFF_FFFD, lat);
      checkOutput("load_r3_flag_n", fn32, 1'b1);
      applyStimulus(1'b0, OP_ALU, FN_ADD, 4'd1, 4'd2, 4'd3, 1'b0, 32'd0, lat);
      checkOutput("add_latency", lat, 4);
      readReg(1'b0, 4'd1, v);
      checkOutput("add_r1", v, 32'h4);
      checkOutput("add_flags", {fz32, fn32}, 2'b00);

      applyStimulus(1'b0, OP_ALU, FN_ROR, 4'd4, 4'd2, 4'd0, 1'b1, 32'h21, lat);
      readReg(1'b0, 4'd4, v);
      checkOutput("ror_r4", v, 32'h8000_0003);
      checkOutput("ror_flag_n", fn32, 1'b1);

      applyStimulus(1'b0, OP_ALU, FN_SUB, 4'd7, 4'd2, 4'd0, 1'b1, 32'h9, lat);
      readReg(1'b0, 4'd7, v);
      checkOutput("sub_r7", v, 32'hFFFF_FFFE);

      applyStimulus(1'b0, OP_MUL, 4'd0, 4'd9, 4'd2, 4'd3, 1'b0, 32'd0, lat);
      checkOutput("mul_latency", lat, 4);
      checkOutput("mul_hi", hi32, 32'hFFFF_FFFF);
      checkOutput("mul_lo", lo32, 32'hFFFF_FFEB);
      checkOutput("mul_flags", {fz32, fn32}, 2'b01);
      readReg(1'b0, 4'd9, v);
      checkOutput("mul_rfile_r9", v, 32'h0);
      readReg(1'b0, 4'd2, v);
      checkOutput("mul_rfile_r2", v, 32'h7);

      // Back-to-back: hold valid through two ADD R1,R1,#1 from R1 = 0
      applyStimulus(1'b0, OP_ALU, FN_ADD, 4'd1, 4'd0, 4'd0, 1'b1, 32'h0, lat);
      @(posedge clk);
      @(negedge clk);
      setCmd(1'b0, OP_ALU, FN_ADD, 4'd1, 4'd1, 4'd0, 1'b1, 32'h1);
      accepts = 0;
      cyc1    = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (bus32.cmd_ready) begin
            if (accepts == 2) begin
               bus32.cmd_valid = 1'b0;
               break;
            end
            accepts++;
            if (accepts == 1) begin
               cyc1 = cyc;
            end else begin
               checkOutput("b2b_done_at_accept", bus32.done, 1'b1);
               checkOutput("b2b_gap", cyc - cyc1, 4);
            end
         end
         @(negedge clk);
      end
      bus32.cmd_valid = 1'b0;
      checkOutput("b2b_accepts", accepts, 2);
      readReg(1'b0, 4'd1, v);
      checkOutput("b2b_r1", v, 32'h2);

      applyStimulus(1'b0, OP_RSVD, 4'd0, 4'd1, 4'd0, 4'd0, 1'b1, 32'h99, lat);
      checkOutput("rsvd_latency", lat, 1);
      readReg(1'b0, 4'd1, v);
      checkOutput("rsvd_r1_kept", v, 32'h2);
      checkOutput("rsvd_hi_kept", hi32, 32'hFFFF_FFFF);

      resetDuringExec(1'b0, 4'd6, 32'h33);
      readReg(1'b0, 4'd2, v);
      checkOutput("rstx_r2_cleared", v, 32'h0);
      checkOutput("rstx_hilo_cleared", {hi32, lo32}, 64'h0);

      // Narrow instance: 8-bit words, four registers
      resetDuringExec(1'b1, 4'd3, 32'h44);
      applyStimulus(1'b1, OP_ALU, FN_ADD, 4'd1, 4'd0, 4'd0, 1'b1, 32'hFF, lat);
      applyStimulus(1'b1, OP_ALU, FN_ADD, 4'd2, 4'd0, 4'd0, 1'b1, 32'h02, lat);
      applyStimulus(1'b1, OP_ALU, FN_ADD, 4'd3, 4'd1, 4'd2, 1'b0, 32'd0, lat);
      checkOutput("w8_add_latency", lat, 4);
      readReg(1'b1, 4'd3, v);
      checkOutput("w8_add_wrap", v, 32'h01);
      checkOutput("w8_add_flags", {fz8, fn8}, 2'b00);

      applyStimulus(1'b1, OP_ALU, FN_ADD, 4'd1, 4'd0, 4'd0, 1'b1, 32'h80, lat);
      applyStimulus(1'b1, OP_ALU, FN_SHRA, 4'd2, 4'd1, 4'd0, 1'b1, 32'h09, lat);
      readReg(1'b1, 4'd2, v);
      checkOutput("w8_shra", v, 32'hC0);
      checkOutput("w8_shra_flag_n", fn8, 1'b1);
      applyStimulus(1'b1, OP_ALU, FN_ROL, 4'd3, 4'd1, 4'd0, 1'b1, 32'h01, lat);
      readReg(1'b1, 4'd3, v);
      checkOutput("w8_rol", v, 32'h01);

      applyStimulus(1'b1, OP_MUL, 4'd0, 4'd3, 4'd1, 4'd1, 1'b0, 32'd0, lat);
      checkOutput("w8_mul_hilo", {hi8, lo8}, 16'h4000);
      checkOutput("w8_mul_flags", {fz8, fn8}, 2'b00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rt_datapath_core.md
# rt_datapath_core

Parametrised register-transfer datapath core: a general-purpose register file, a Y staging register, a double-width Z result register, HI/LO registers and an integrated ALU. A built-in micro-sequencer runs complete MOVE, ALU and MUL register transfers from a single valid/ready command. External control no longer drives per-cycle bus strobes. It is the next-generation datapath for the CPU, generalised in word width and register count, with an optional hard-zero R0.

## Interface
Parameters:
- DATA_W, 32, word width of registers, Y, HI, LO and each half of Z
- NUM_REGS, 16, number of general-purpose registers; REG_AW = clog2(NUM_REGS), derived
- R0_ZERO, 1, when 1, R0 reads as 0 and writes to R0 are discarded

Ports:
- clk  in  1  clock; all state changes on the rising edge
- clr  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  core idle and able to accept
- cmd_op  in  2  00 MOVE, 01 ALU, 10 MUL, 11 reserved (accepted, no state change, done pulses)
- cmd_alu  in  4  ALU function; ignored unless cmd_op = ALU
- cmd_ra / cmd_rb / cmd_rc  in  REG_AW each  destination / operand A / operand B register
- cmd_use_imm  in  1  operand B is cmd_imm instead of R[rc]
- cmd_imm  in  DATA_W  immediate operand
- done  out  1  one-cycle pulse; results are architecturally visible in this cycle
- flag_z / flag_n  out  1  zero / sign of the last written result
- hi_out / lo_out  out  DATA_W  HI / LO contents
- dbg_addr  in  REG_AW;  dbg_data  out  DATA_W  combinational register-file read port

## Operation
- States: IDLE, LOAD_Y, EXEC, WRITE. cmd_ready = (state == IDLE).
- Accept on an edge with cmd_valid && cmd_ready: latch all cmd_* fields. MOVE goes to WRITE. ALU and MUL go to LOAD_Y. Reserved goes to IDLE with done set.
- LOAD_Y: Y <= R[rb].
- EXEC: Z <= alu(Y, B). B = cmd_imm if use_imm, otherwise R[rc], sampled this cycle.
- WRITE:
  - MOVE: R[ra] <= R[rb].
  - ALU: R[ra] <= Zlow.
  - MUL: HI <= Zhigh, LO <= Zlow. The register file is untouched.
  - flag_z and flag_n are updated from the value written (for MUL, from the full 2·DATA_W product). done <= 1. Next state is IDLE.
- ALU functions (A = Y): 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 SHR, 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 NEG (−B), 10 NOT (~B). 11–15 are reserved and produce Z = 0.
- Width rules:
  - ADD, SUB and NEG wrap modulo 2^DATA_W.
  - Shift and rotate amounts are B[clog2(DATA_W)−1:0]. Rotates are modulo DATA_W.
  - Zhigh = 0 for every non-MUL function.
  - MUL is signed DATA_W × DATA_W, giving 2·DATA_W bits.
- R0_ZERO = 1: R0 reads 0 on every path (operands, MOVE source, dbg_data). Writes to R0 are dropped, but flags and done still update.
- Source equals destination (e.g. ra = rb) is legal. Operands are sampled before the WRITE edge.

## Timing
- Reset (clr = 0 at an edge): state = IDLE and all registers, Y, Z, HI, LO and flags = 0. done = 0 in the next cycle. Any in-flight command is discarded and no partial writeback occurs. Reset has priority over acceptance.
- Latency from the accept edge to done high:
  - MOVE: 2 cycles (WRITE, then IDLE with done).
  - ALU / MUL: 4 cycles (LOAD_Y, EXEC, WRITE, then IDLE with done).
- done and cmd_ready are both high in the post-WRITE cycle, so back-to-back acceptance happens at that edge. A dependent command then sees the new value.
- cmd_valid may be held with changing fields while cmd_ready = 0; only the fields present at the accept edge matter.
- dbg_data is combinational. It reflects a write in the cycle after the WRITE edge.

## Structure
- Package rt_pkg holds:
  - cmd_op encodings
  - ALU function encodings
  - the state enum (IDLE/LOAD_Y/EXEC/WRITE)
- Sub-module rt_alu(DATA_W): purely combinational, with inputs A, B and function, and a 2·DATA_W output. The sequencer, register file, Y, Z and HI/LO live in rt_datapath_core.

## Test plan
- Reset, then MOVE R5 <- R0 with R0_ZERO=1 -> done 2 cycles after accept, R5 = 0, flag_z = 1; MOVE R0 <- R5 leaves dbg_data(R0) = 0.
- Load R2 = 0x00000007 and R3 = 0xFFFFFFFD, then ALU ADD R1, R2, R3 -> done 4 cycles after accept, R1 = 0x00000004, flag_z = 0, flag_n = 0.
- ALU ROR R4, R2, imm 0x21 (DATA_W = 32) -> rotate by 1, R4 = 0x80000003, flag_n = 1.
- MUL R2 × R3 (7 × −3) -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB, R-file unchanged, flag_n = 1.
- Hold cmd_valid through two commands: ADD R1, R1, imm 1 twice from R1 = 0 -> second accept on the edge where done is high, final R1 = 2.
- Assert clr low during EXEC of ADD R6 -> R6 = 0, no done pulse, cmd_ready = 1 in the cycle after the reset edge; repeat with DATA_W = 8, NUM_REGS = 4: ADD 0xFF + 0x02 -> 0x01.
